gradient_magnitude_ctrl: RTL

//   Frame sequencer for the combinational gradient magnitude unit (stage 2 of the canny pipeline).

---
 rtl/gradient_magnitude_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/gradient_magnitude_ctrl.sv
// ---------------------------------------------------------------------------
// gradient_magnitude_ctrl
//
// Frame sequencer wrapped around the combinational gradient magnitude unit.
// It takes a raster stream of (gx, gy) pairs, feeds them to the external
// magnitude unit, and registers the returned magnitude together with its
// pixel coordinates. Both sides use a valid/ready handshake, and a single
// output register supports full throughput (one pixel per cycle, one cycle
// of latency). Pixels on the frame border are forced to zero so that
// non-max suppression downstream sees a clean frame edge.
//
// Optional feature, enabled by defining MAG_STATS_EN:
//   adds output max_gmag, the largest interior magnitude of the current frame.
// ---------------------------------------------------------------------------
module gradient_magnitude_ctrl #(
  parameter int IMG_W = 640,  // pixels per row, >= 3
  parameter int IMG_H = 480,  // rows per frame, >= 3
  parameter int CNT_W = 10    // coordinate width, 2**CNT_W >= max(IMG_W, IMG_H)
) (
  input  logic             clk,
  input  logic             n_rst,
  // frame control
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  // upstream gradient stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_gx,
  input  logic [7:0]       in_gy,
  // magnitude unit interface (combinational round trip)
  output logic [7:0]       mag_gx,
  output logic [7:0]       mag_gy,
  input  logic [7:0]       mag_gmag,
  // downstream magnitude stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_gmag,
  output logic [CNT_W-1:0] out_col,
  output logic [CNT_W-1:0] out_row
`ifdef MAG_STATS_EN
  ,
  output logic [7:0]       max_gmag
`endif
);

  // Last column and last row expressed at counter width.
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,   // waiting for start
    S_RUN,    // accepting pixels
    S_DRAIN,  // last pixel accepted, waiting for it to leave the output register
    S_DONE    // one-cycle frame completion pulse
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_gmag_q, out_gmag_d;
  logic [CNT_W-1:0] out_col_q, out_col_d;
  logic [CNT_W-1:0] out_row_q, out_row_d;

  logic running;     // state is RUN
  logic start_ok;    // start honoured this cycle
  logic accept;      // input pair transferred this cycle
  logic consume;     // output register emptied by downstream this cycle
  logic last_pixel;  // counters point at the final pixel of the frame
  logic border;      // counters point at a frame-edge pixel

  // Handshake and position decode shared by the FSM and the datapath.
  always_comb begin
    running    = (state_q == S_RUN);
    start_ok   = (state_q == S_IDLE) && start;
    in_ready   = running && (!out_valid_q || out_ready);
    accept     = in_valid && in_ready;
    consume    = out_valid_q && out_ready;
    last_pixel = (col_q == LAST_COL) && (row_q == LAST_ROW);
    border     = (col_q == '0) || (col_q == LAST_COL) ||
                 (row_q == '0) || (row_q == LAST_ROW);
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)                   state_d = S_RUN;
      S_RUN:   if (accept && last_pixel)    state_d = S_DRAIN;
      S_DRAIN: if (consume)                 state_d = S_DONE;
      S_DONE:                               state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  // Raster counters: cleared on start, advanced per accept, frozen after the last pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (start_ok) begin
      col_d = '0;
      row_d = '0;
    end else if (accept && !last_pixel) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  // Output register: load on accept, empty on consume without a refill, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_gmag_d  = out_gmag_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_gmag_d  = border ? 8'd0 : mag_gmag;
      out_col_d   = col_q;
      out_row_d   = row_q;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_gmag_q  <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, whatever the statement order.
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_gmag_q  <= out_gmag_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
    end
  end

`ifdef MAG_STATS_EN
  logic [7:0] max_q, max_d;

  // Running maximum of interior magnitudes; cleared by an honoured start.
  always_comb begin
    max_d = max_q;
    if (start_ok) begin
      max_d = '0;
    end else if (accept && !border && (mag_gmag > max_q)) begin
      max_d = mag_gmag;
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  assign max_gmag = max_q;
`endif

  // Gate the magnitude unit inputs so they stay quiet outside RUN.
  assign mag_gx = running ? in_gx : 8'd0;
  assign mag_gy = running ? in_gy : 8'd0;

  // Registered stream outputs and state-decoded status.
  assign out_valid  = out_valid_q;
  assign out_gmag   = out_gmag_q;
  assign out_col    = out_col_q;
  assign out_row    = out_row_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign frame_done = (state_q == S_DONE);

endmodule
